// File: rtl/breakout_pkg.sv
// Shared breakout types: collision FSM states, brick geometry, ball size.
// Optional diagonal probe is enabled by BALL_COL_DIAG_EN.
package breakout_pkg;

  localparam int BRICK_W   = 8;
  localparam int BRICK_H   = 4;
  localparam int BRICK_WSH = 3;
  localparam int BRICK_HSH = 2;
  localparam int ROW_BITS  = 3;
  localparam int COL_BITS  = 5;
  localparam int ADDR_W    = ROW_BITS + COL_BITS;
  localparam int BALL_SIZE = 3;

  typedef enum logic [3:0] {
    IDLE,
    WALLS,
    PROBE_H,
    WAIT_H,
    PROBE_V,
    WAIT_V,
    PROBE_D,
    WAIT_D,
    REPORT
  } state_t;

  // 9-bit signed so that x-1 at x=0 reads as negative
  typedef logic signed [8:0] coord_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/brick_cell_map.sv
// Pixel to brick-cell mapping: field membership and RAM address.
// Combinational; shared by the H, V and D probes.
module brick_cell_map
  import breakout_pkg::*;
#(
  parameter int BRICK_Y0   = 8,
  parameter int BRICK_ROWS = 6,
  parameter int BRICK_COLS = 20
) (
  input  coord_t              px,
  input  coord_t              py,
  output logic                in_field,
  output logic [ADDR_W-1:0]   addr
);

  coord_t dy;

  assign dy = py - coord_t'(BRICK_Y0);

  assign in_field =
    (px >= coord_t'(0)) &&
    (px <  coord_t'(BRICK_COLS * BRICK_W)) &&
    (dy >= coord_t'(0)) &&
    (dy <  coord_t'(BRICK_ROWS * BRICK_H));

  assign addr = {dy[BRICK_HSH +: ROW_BITS],
                 px[BRICK_WSH +: COL_BITS]};

endmodule

// File: rtl/ball_collision.sv
// Ball collision detector: walls, paddle and brick-map probes per move.
// Define BALL_COL_DIAG_EN to add the diagonal (D) brick probe.
module ball_collision
  import breakout_pkg::*;
#(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int PADDLE_Y   = 112,
  parameter int PADDLE_W   = 16,
  parameter int BRICK_Y0   = 8,
  parameter int BRICK_ROWS = 6,
  parameter int BRICK_COLS = 20
) (
  input  logic              clock,
  input  logic              reset_dividers,
  input  logic              start,
  input  logic [7:0]        ball_x_top,
  input  logic [6:0]        ball_y_top,
  input  logic              h_q,
  input  logic              v_q,
  input  logic [7:0]        paddle_x,
  output logic [ADDR_W-1:0] brick_addr,
  input  logic              brick_hit,
  output logic              brick_clear,
  output logic [1:0]        h_col_count,
  output logic [1:0]        v_col_count,
  output logic [1:0]        d_col_count,
  output logic              paddle_collision,
  output logic              ball_lost,
  output logic              done
);

  state_t state, state_n;

  logic [7:0] bx, pad;
  logic [6:0] by;
  logic       hd, vd;
  logic       probe_on;
  logic [1:0] h_cnt, v_cnt;

  coord_t x0, y0, p0;
  coord_t x_lead, y_lead;
  coord_t cell_x, cell_y;

  logic              h_wall, v_wall;
  logic              pad_hit, lost;
  logic              cell_in;
  logic [ADDR_W-1:0] cell_addr;

  assign x0 = coord_t'({1'b0, bx});
  assign y0 = coord_t'({2'b00, by});
  assign p0 = coord_t'({1'b0, pad});

  assign x_lead = hd ? x0 + coord_t'(BALL_SIZE)
                     : x0 - coord_t'(1);
  assign y_lead = vd ? y0 + coord_t'(BALL_SIZE)
                     : y0 - coord_t'(1);

  assign h_wall = (x_lead < coord_t'(0)) ||
                  (x_lead >= coord_t'(SCREEN_W));
  assign v_wall = (y_lead < coord_t'(0));

  assign pad_hit =
    vd && (y_lead == coord_t'(PADDLE_Y)) &&
    (x0 + coord_t'(BALL_SIZE - 1) >= p0) &&
    (x0 <= p0 + coord_t'(PADDLE_W - 1));

  assign lost = vd && (y_lead >= coord_t'(SCREEN_H));

  // Cell for the probe that is about to be presented
  always_comb begin
    cell_x = x_lead;
    cell_y = y_lead;
    unique case (1'b1)
      (state == WALLS): begin
        cell_x = x_lead;
        cell_y = y0 + coord_t'(1);
      end
      (state == WAIT_H): begin
        cell_x = x0 + coord_t'(1);
        cell_y = y_lead;
      end
      default: ;
    endcase
  end

  brick_cell_map #(
    .BRICK_Y0   (BRICK_Y0),
    .BRICK_ROWS (BRICK_ROWS),
    .BRICK_COLS (BRICK_COLS)
  ) u_map (
    .px       (cell_x),
    .py       (cell_y),
    .in_field (cell_in),
    .addr     (cell_addr)
  );

  always_comb begin
    state_n     = state;
    brick_clear = 1'b0;
    case (state)
      IDLE:    if (start) state_n = WALLS;
      WALLS:   state_n = PROBE_H;
      PROBE_H: state_n = WAIT_H;
      WAIT_H: begin
        brick_clear = probe_on & brick_hit;
        state_n     = PROBE_V;
      end
      PROBE_V: state_n = WAIT_V;
      WAIT_V: begin
        brick_clear = probe_on & brick_hit;
`ifdef BALL_COL_DIAG_EN
        state_n     = PROBE_D;
`else
        state_n     = REPORT;
`endif
      end
`ifdef BALL_COL_DIAG_EN
      PROBE_D: state_n = WAIT_D;
      WAIT_D: begin
        brick_clear = probe_on & brick_hit;
        state_n     = REPORT;
      end
`endif
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef BALL_COL_DIAG_EN
  logic [1:0] d_cnt;
  logic       d_go;

  // D runs only when neither axis saw any hit this pass
  assign d_go = cell_in && (h_cnt == 2'd0) &&
                (v_cnt == 2'd0) && !brick_clear;

  always_ff @(posedge clock or negedge reset_dividers) begin
    if (!reset_dividers) begin
      d_cnt <= 2'd0;
    end else if (state == IDLE && start) begin
      d_cnt <= 2'd0;
    end else if (state == WAIT_D && brick_clear) begin
      d_cnt <= sat_inc(d_cnt);
    end
  end

  assign d_col_count = d_cnt;
`else
  assign d_col_count = 2'd0;
`endif

  always_ff @(posedge clock or negedge reset_dividers) begin
    if (!reset_dividers) begin
      state            <= IDLE;
      bx               <= '0;
      by               <= '0;
      hd               <= 1'b0;
      vd               <= 1'b0;
      pad              <= '0;
      probe_on         <= 1'b0;
      brick_addr       <= '0;
      h_cnt            <= 2'd0;
      v_cnt            <= 2'd0;
      paddle_collision <= 1'b0;
      ball_lost        <= 1'b0;
      done             <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == REPORT);
      case (state)
        IDLE: if (start) begin
          bx               <= ball_x_top;
          by               <= ball_y_top;
          hd               <= h_q;
          vd               <= v_q;
          pad              <= paddle_x;
          h_cnt            <= 2'd0;
          v_cnt            <= 2'd0;
          paddle_collision <= 1'b0;
          ball_lost        <= 1'b0;
        end
        WALLS: begin
          h_cnt            <= {1'b0, h_wall};
          v_cnt            <= {1'b0, v_wall | pad_hit};
          paddle_collision <= pad_hit;
          ball_lost        <= lost;
          probe_on         <= cell_in;
          if (cell_in) brick_addr <= cell_addr;
        end
        WAIT_H: begin
          if (brick_clear) h_cnt <= sat_inc(h_cnt);
          probe_on <= cell_in;
          if (cell_in) brick_addr <= cell_addr;
        end
        WAIT_V: begin
          if (brick_clear) v_cnt <= sat_inc(v_cnt);
`ifdef BALL_COL_DIAG_EN
          probe_on <= d_go;
          if (d_go) brick_addr <= cell_addr;
`else
          probe_on <= 1'b0;
`endif
        end
        REPORT: probe_on <= 1'b0;
        default: ;
      endcase
    end
  end

  assign h_col_count = h_cnt;
  assign v_col_count = v_cnt;

endmodule

// File: tb/tb_ball_collision.sv
// Scoreboard bench for ball_collision: walls, paddle, bricks, reset.
// Expectations follow BALL_COL_DIAG_EN when it is defined.
module tb_ball_collision;

`ifdef BALL_COL_DIAG_EN
  localparam int LAT = 8;
  localparam bit DG  = 1'b1;
`else
  localparam int LAT = 6;
  localparam bit DG  = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] h;
    logic [1:0] v;
    logic [1:0] d;
    logic       pad;
    logic       lost;
  } res_t;

  logic       clock = 1'b0;
  logic       reset_dividers = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ball_x_top = '0;
  logic [6:0] ball_y_top = '0;
  logic       h_q = 1'b0;
  logic       v_q = 1'b0;
  logic [7:0] paddle_x = '0;
  logic [7:0] brick_addr;
  logic       brick_hit = 1'b0;
  logic       brick_clear;
  logic [1:0] h_col_count, v_col_count, d_col_count;
  logic       paddle_collision, ball_lost, done;

  bit         bricks [256];
  res_t       sb [$];
  logic [7:0] clr_seen [$];
  int         vectors = 0;
  int         errors  = 0;

  ball_collision dut (
    .clock            (clock),
    .reset_dividers   (reset_dividers),
    .start            (start),
    .ball_x_top       (ball_x_top),
    .ball_y_top       (ball_y_top),
    .h_q              (h_q),
    .v_q              (v_q),
    .paddle_x         (paddle_x),
    .brick_addr       (brick_addr),
    .brick_hit        (brick_hit),
    .brick_clear      (brick_clear),
    .h_col_count      (h_col_count),
    .v_col_count      (v_col_count),
    .d_col_count      (d_col_count),
    .paddle_collision (paddle_collision),
    .ball_lost        (ball_lost),
    .done             (done)
  );

  always #5 clock = ~clock;

  // Brick RAM: one-cycle read latency
  always @(posedge clock) brick_hit <= bricks[brick_addr];

  task automatic run_pass(
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       h,
    input  logic       v,
    input  logic [7:0] pad,
    input  bit         mid,
    output res_t       obs,
    output int         lat
  );
    clr_seen.delete();
    obs = '0;
    @(negedge clock);
    ball_x_top = x;
    ball_y_top = y;
    h_q = h;
    v_q = v;
    paddle_x = pad;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clock);
      lat++;
      #1;
      start = mid && (lat == 3);
      if (brick_clear) clr_seen.push_back(brick_addr);
      if (done) break;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      vectors++;
      errors++;
      $display("FAIL timeout: done=%b after %0d cycles, need 1", done, lat);
    end else begin
      obs = {h_col_count, v_col_count, d_col_count,
             paddle_collision, ball_lost};
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({done, brick_clear, h_col_count, v_col_count, d_col_count,
         paddle_collision, ball_lost, brick_addr} !== 19'd0) begin
      errors++;
      $display("FAIL reset: outs=%h addr=%h, need all 0",
               {done, brick_clear, h_col_count, v_col_count,
                d_col_count, paddle_collision, ball_lost}, brick_addr);
    end
    @(negedge clock) reset_dividers = 1'b1;
  endtask

  task automatic test_h_wall();
    res_t obs, e;
    int   lat;
    sb.push_back('{h:2'd1, v:2'd0, d:2'd0, pad:1'b0, lost:1'b0});
    run_pass(8'd157, 7'd50, 1'b1, 1'b0, 8'd0, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL h_wall: got %h need %h", obs, e);
    end
    vectors++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL h_wall_latency: got %0d need %0d", lat, LAT);
    end
  endtask

  task automatic test_paddle();
    res_t obs, e;
    int   lat;
    sb.push_back('{h:2'd0, v:2'd1, d:2'd0, pad:1'b1, lost:1'b0});
    run_pass(8'd60, 7'd109, 1'b0, 1'b1, 8'd55, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL paddle_hit: got %h need %h", obs, e);
    end
    sb.push_back('{h:2'd0, v:2'd0, d:2'd0, pad:1'b0, lost:1'b0});
    run_pass(8'd60, 7'd109, 1'b0, 1'b1, 8'd70, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL paddle_miss: got %h need %h", obs, e);
    end
  endtask

  task automatic test_ball_lost();
    res_t obs, e;
    int   lat;
    sb.push_back('{h:2'd0, v:2'd0, d:2'd0, pad:1'b0, lost:1'b1});
    run_pass(8'd60, 7'd118, 1'b0, 1'b1, 8'd55, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ball_lost: got %h need %h", obs, e);
    end
  endtask

  task automatic test_brick_v();
    res_t obs, e;
    int   lat;
    bricks[8'h65] = 1'b1;
    sb.push_back('{h:2'd0, v:2'd1, d:2'd0, pad:1'b0, lost:1'b0});
    run_pass(8'd40, 7'd21, 1'b0, 1'b0, 8'd0, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL brick_v: got %h need %h", obs, e);
    end
    vectors++;
    if (clr_seen.size() != 1 || clr_seen[0] !== 8'h65) begin
      errors++;
      $display("FAIL brick_v_clear: got %0d strobes first=%h need 1 at 65",
               clr_seen.size(), clr_seen.size() ? clr_seen[0] : 8'h00);
    end
    bricks[8'h65] = 1'b0;
  endtask

  task automatic test_diag();
    res_t obs, e;
    int   lat;
    bricks[8'hA1] = 1'b1;
    sb.push_back('{h:2'd0, v:2'd0, d:{1'b0, DG}, pad:1'b0, lost:1'b0});
    run_pass(8'd15, 7'd32, 1'b0, 1'b0, 8'd0, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL diag: got %h need %h", obs, e);
    end
    vectors++;
    if (clr_seen.size() != int'(DG) ||
        (DG && clr_seen[0] !== 8'hA1)) begin
      errors++;
      $display("FAIL diag_clear: got %0d strobes need %0d at a1",
               clr_seen.size(), DG);
    end
    vectors++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL diag_latency: got %0d need %0d", lat, LAT);
    end
    bricks[8'hA1] = 1'b0;
  endtask

  task automatic test_corner();
    res_t obs, e;
    int   lat;
    int   extra;
    sb.push_back('{h:2'd1, v:2'd1, d:2'd0, pad:1'b0, lost:1'b0});
    run_pass(8'd0, 7'd0, 1'b0, 1'b0, 8'd0, 1'b1, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL corner: got %h need %h", obs, e);
    end
    vectors++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL corner_latency: got %0d need %0d", lat, LAT);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1 if (done) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL mid_start: got %0d extra done pulses need 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    bricks[8'h24] = 1'b1;
    @(negedge clock);
    ball_x_top = 8'd30;
    ball_y_top = 7'd12;
    h_q = 1'b1;
    v_q = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_dividers = 1'b0;
    #1;
    vectors++;
    if ({done, brick_clear, h_col_count, v_col_count, d_col_count,
         paddle_collision, ball_lost, brick_addr} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid: outs=%h addr=%h hit=%b, need all 0",
               {done, brick_clear, h_col_count, v_col_count,
                d_col_count, paddle_collision, ball_lost},
               brick_addr, brick_hit);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset_dividers = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1 if (done || brick_clear) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d done/clear cycles need 0", extra);
    end
    bricks[8'h24] = 1'b0;
  endtask

  task automatic test_back_to_back();
    res_t obs, e;
    int   lat;
    bricks[8'h24] = 1'b1;
    bricks[8'h65] = 1'b1;
    sb.push_back('{h:2'd1, v:2'd0, d:2'd0, pad:1'b0, lost:1'b0});
    sb.push_back('{h:2'd0, v:2'd1, d:2'd0, pad:1'b0, lost:1'b0});
    run_pass(8'd30, 7'd12, 1'b1, 1'b0, 8'd0, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || clr_seen.size() != 1 || clr_seen[0] !== 8'h24) begin
      errors++;
      $display("FAIL b2b_first: got %h (%0d clears) need %h (1 at 24)",
               obs, clr_seen.size(), e);
    end
    run_pass(8'd40, 7'd21, 1'b0, 1'b0, 8'd0, 1'b0, obs, lat);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || clr_seen.size() != 1 || clr_seen[0] !== 8'h65) begin
      errors++;
      $display("FAIL b2b_second: got %h (%0d clears) need %h (1 at 65)",
               obs, clr_seen.size(), e);
    end
    vectors++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL b2b_latency: got %0d need %0d", lat, LAT);
    end
    bricks[8'h24] = 1'b0;
    bricks[8'h65] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bricks[i] = 1'b0;
    test_reset();
    test_h_wall();
    test_paddle();
    test_ball_lost();
    test_brick_v();
    test_diag();
    test_corner();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at 200000, need finish");
    $fatal(1);
  end

endmodule
